// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues in-order imem requests from pc_in, tags responses with their PC and buffers
// {pc, instr} for decode. Optional perf counters under IF_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
  parameter int BUF_DEPTH  = 4,
  parameter int RESET_DROP = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_hold,
  input  logic        flush,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {FETCH, DRAIN} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  state_t        state;
  logic [CW-1:0] outstanding, occupancy, drop, drop_sum, drop_next;
  logic [AW-1:0] tq_wr, tq_rd, fb_wr, fb_rd;
  logic [31:0]   tag_q [BUF_DEPTH];
  fetch_entry_t  fbuf  [BUF_DEPTH];
  logic [CW:0]   in_use;
  logic          req_fire, resp_keep, resp_count, deq;

  // Credit covers both in-flight and buffered entries, so a kept response always finds room.
  assign in_use         = {1'b0, outstanding} + {1'b0, occupancy};
  assign imem_req_valid = ~reset & (state == FETCH) & ~flush & (in_use < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_in;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign pc_hold        = ~req_fire;
  assign resp_count     = imem_resp_valid & (drop == '0);
  assign resp_keep      = resp_count & ~flush;
  assign if_valid       = (occupancy != '0);
  assign deq            = if_valid & id_ready;
  assign if_pc          = fbuf[fb_rd].pc;
  assign if_instr       = fbuf[fb_rd].instr;
  assign drop_sum       = drop + outstanding;

  always_comb begin
    drop_next = drop;
    if (flush)
      drop_next = drop_sum - CW'(imem_resp_valid && (drop_sum != '0));
    else if (imem_resp_valid && (drop != '0))
      drop_next = drop - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      outstanding <= '0;
      occupancy   <= '0;
      drop        <= CW'(RESET_DROP);
      tq_wr       <= '0;
      tq_rd       <= '0;
      fb_wr       <= '0;
      fb_rd       <= '0;
    end else begin
      if (req_fire)        tq_wr <= tq_wr + AW'(1);
      // Every response pops a tag, dropped or kept; the queue outlives a flush for that reason.
      if (imem_resp_valid) tq_rd <= tq_rd + AW'(1);
      drop  <= drop_next;
      state <= (drop_next != '0) ? DRAIN : FETCH;
      if (flush) begin
        outstanding <= '0;
        occupancy   <= '0;
        fb_wr       <= '0;
        fb_rd       <= '0;
      end else begin
        outstanding <= outstanding + CW'(req_fire) - CW'(resp_count);
        occupancy   <= occupancy + CW'(resp_keep) - CW'(deq);
        if (resp_keep) fb_wr <= fb_wr + AW'(1);
        if (deq)       fb_rd <= fb_rd + AW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && req_fire)  tag_q[tq_wr] <= pc_in;
    if (!reset && resp_keep) fbuf[fb_wr]  <= '{pc: tag_q[tq_rd], instr: imem_resp_data};
  end

`ifdef IF_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (resp_keep) perf_fetched <= perf_fetched + 32'd1;
      if (pc_hold)   perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

  assert property (@(posedge clock) disable iff (reset) resp_keep |-> (occupancy != CW'(BUF_DEPTH)));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench: a transaction-level memory model and an expected-fetch queue
// (PCs accepted since the last flush, in order) checked against the decode-side stream.
module tb_instruction_fetch_unit;
  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pc_hold;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        id_ready = 1'b0;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  instruction_fetch_unit #(.BUF_DEPTH(D), .RESET_DROP(0)) dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .pc_hold(pc_hold), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready)
`ifdef IF_PERF_COUNTERS_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  int          cyc = 0, last_due = 0;
  int          n_checks = 0, n_err = 0;
  int          n_fetched = 0, n_stall = 0;
  bit          last_fire = 0, prev_rst = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus plus the memory model; checks the request side.
  task automatic cycle(input bit rst, input bit fl, input bit rdy, input bit idr,
                       input logic [31:0] pc, input int lmin, input int lmax);
    mreq_t m;
    int    stale_n, live, due;
    bit    exp_v;
    @(negedge clock);
    cyc++;
    reset = rst; flush = fl; imem_req_ready = rdy; id_ready = idr; pc_in = pc;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    stale_n = 0;
    live = exp_q.size();
    if (rst) begin
      mq.delete(); exp_q.delete();
      last_due = cyc; n_fetched = 0; n_stall = 0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(m.addr);
      if (m.stale) stale_n++;
      else if (!fl) n_fetched++;
    end
    foreach (mq[i]) if (mq[i].stale) stale_n++;
    #2;
    exp_v = !rst && !fl && stale_n == 0 && live < D;
    check("req_valid", 32'(imem_req_valid), 32'(exp_v));
    check("req_addr", imem_req_addr, pc);
    check("pc_hold", 32'(pc_hold), 32'(!(exp_v && rdy)));
    if (rst && prev_rst) begin
      check("reset_if_valid", 32'(if_valid), 32'd0);
      check("reset_req_valid", 32'(imem_req_valid), 32'd0);
    end
    prev_rst = rst;
    if (!rst && !(exp_v && rdy)) n_stall++;
    if (fl) begin
      exp_q.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
    end
    last_fire = !rst && imem_req_valid && rdy;
    if (last_fire) begin
      due = cyc + $urandom_range(lmin, lmax);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: pc, due: due, stale: 1'b0});
      exp_q.push_back(pc);
    end
  endtask

  // Decode-side monitor: every valid head must match the oldest live expected fetch.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      #1;
      if (!reset && if_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_if_valid", 32'(if_valid), 32'd0);
        end else begin
          e = exp_q[0];
          check("if_pc", if_pc, e);
          check("if_instr", if_instr, mem_word(e));
          if (id_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    bit          fl, rdy, idr;
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 32'h0, 1, 1);
    pc = 32'h0;
    // Streaming, latency 1
    for (int i = 0; i < 30; i++) begin
      cycle(0, 0, 1, 1, pc, 1, 1);
      if (last_fire) pc = pc + 32'd4;
    end
    // Decode back-pressure fills the buffer, then releases
    for (int i = 0; i < 24; i++) begin
      cycle(0, 0, 1, i >= 12, pc, 1, 1);
      if (last_fire) pc = pc + 32'd4;
    end
    // Latency 3 with requests in flight, then redirect to 0x100
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 1, pc, 3, 3);
      if (last_fire) pc = pc + 32'd4;
    end
    cycle(0, 1, 1, 1, pc, 3, 3);
    pc = 32'h100;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1, 1, pc, 1, 3);
      if (last_fire) pc = pc + 32'd4;
    end
    // Flush coinciding with a response, single outstanding
    cycle(0, 0, 0, 1, pc, 1, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, pc, 1, 1);
    cycle(0, 0, 1, 1, pc, 1, 1);
    if (last_fire) pc = pc + 32'd4;
    cycle(0, 1, 1, 1, pc, 1, 1);
    pc = 32'h200;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 1, pc, 1, 1);
      if (last_fire) pc = pc + 32'd4;
    end
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      idr = ($urandom_range(0, 3) != 0);
      cycle(0, fl, rdy, idr, pc, 1, 4);
      if (fl) pc = $urandom & 32'hFFFF_FFFC;
      else if (last_fire) pc = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc + 32'd4;
    end
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, pc, 1, 1);
    // Reset with buffered entries
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 1, 0, pc, 1, 1);
      if (last_fire) pc = pc + 32'd4;
    end
    cycle(1, 0, 1, 0, pc, 1, 1);
    cycle(1, 0, 1, 0, pc, 1, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 1, $urandom_range(0, 1), pc, 1, 4);
      if (last_fire) pc = pc + 32'd4;
    end
    // Drain: no new requests; every accepted fetch must have reached decode
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, pc, 1, 1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
`ifdef IF_PERF_COUNTERS_EN
    @(negedge clock);
    #1;
    check("perf_fetched", perf_fetched, 32'(n_fetched));
    check("perf_stall", perf_stall, 32'(n_stall));
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
